// File: rtl/seq_alu_unit.sv
// Sequential add/sub/logic/compare unit with a shift-add multiplier.
// Accepts one operation at a time over valid/ready and holds the result until the consumer takes it.
module seq_alu_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               eq,
  output logic               lt,
  output logic               gt,
  output logic               err
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // MUL   | shift-add iterations in progress
  // DONE  | result held, out_valid high until out_ready
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   acc_next;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            eq    <= (a == b);
            lt    <= (a < b);
            gt    <= (a > b);
            carry <= 1'b0;
            err   <= 1'b0;
            state <= DONE;
            case (op)
              OP_ADD: begin
                result <= {{(WIDTH-1){1'b0}}, sum};
                carry  <= sum[WIDTH];
              end
              OP_SUB: begin
                result <= {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                carry  <= diff[WIDTH];
              end
              OP_AND: result <= {{WIDTH{1'b0}}, a & b};
              OP_OR:  result <= {{WIDTH{1'b0}}, a | b};
              OP_XOR: result <= {{WIDTH{1'b0}}, a ^ b};
              OP_CMP: result <= '0;
              OP_MUL: begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= CNT_W'(WIDTH);
                state  <= MUL;
              end
              default: begin
                result <= '0;
                err    <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt - 1'b1;
          // final iteration lands its partial product straight into result
          if (cnt == CNT_W'(1)) begin
            result <= acc_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Bench for seq_alu_unit: directed and random operations against an arithmetic reference model.
module tb_seq_alu_unit;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           carry, eq, lt, gt, err;

  int total = 0;
  int bad = 0;

  seq_alu_unit #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .eq(eq), .lt(lt), .gt(gt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: {err, carry, result} from plain integer arithmetic
  function automatic logic [2*W+1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int ix = int'(x);
    int iy = int'(y);
    int r = 0;
    logic c = 1'b0;
    logic e = 1'b0;
    case (o)
      3'd0: begin r = ix + iy; c = (r >= (1 << W)); end
      3'd1: begin r = (ix - iy + (1 << W)) % (1 << W); c = (ix < iy); end
      3'd2: r = ix & iy;
      3'd3: r = ix | iy;
      3'd4: r = ix ^ iy;
      3'd5: r = 0;
      3'd6: r = ix * iy;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, c, r[2*W-1:0]};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_flags"}, {carry, eq, lt, gt, err}, 5'b0);
  endtask

  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic early_ready);
    logic [2*W+1:0] exp;
    int lat = 1;
    out_ready = early_ready;
    start_op(o, x, y);
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (o == 3'd6) ? W + 1 : 1);
    exp = model(o, x, y);
    chk("result", result, exp[2*W-1:0]);
    chk("carry", carry, exp[2*W]);
    chk("err", err, exp[2*W+1]);
    chk("flags", {eq, lt, gt}, {x == y, x < y, x > y});
  endtask

  task automatic finish_op(input int hold, input logic [2*W-1:0] exp_res);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      op = 3'd0; a = 4'hf; b = 4'hf;
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", result, exp_res);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    logic [2*W+1:0] e;

    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_release_in_ready", in_ready, 1'b1);

    run_op(3'd0, 4'b1110, 4'b0011, 1'b0); finish_op(0, 8'b00010001);
    run_op(3'd1, 4'b1010, 4'b0101, 1'b0); finish_op(0, 8'b00000101);
    run_op(3'd1, 4'b0011, 4'b1100, 1'b0); finish_op(0, 8'b00000111);
    run_op(3'd5, 4'b1010, 4'b1010, 1'b0); finish_op(0, 8'b0);
    run_op(3'd7, 4'b0110, 4'b1001, 1'b0); finish_op(0, 8'b0);
    run_op(3'd6, 4'b1100, 4'b0011, 1'b0); finish_op(0, 8'd36);
    run_op(3'd6, 4'b1111, 4'b1111, 1'b1); finish_op(0, 8'd225);

    run_op(3'd4, 4'b1010, 4'b0110, 1'b0); finish_op(6, 8'b00001100);
    run_op(3'd3, 4'b1000, 4'b0001, 1'b0); finish_op(1, 8'b00001001);

    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      e = model(ro, ra, rb);
      run_op(ro, ra, rb, 1'b0);
      finish_op(int'($urandom_range(0, 3)), e[2*W-1:0]);
    end

    // asynchronous reset in the middle of the second multiply iteration
    out_ready = 1'b0;
    start_op(3'd6, 4'b1011, 4'b0111);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("mid_mul_reset");
    @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_in_ready", in_ready, 1'b1);
    run_op(3'd0, 4'b0001, 4'b0001, 1'b0); finish_op(0, 8'b00000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
